rgb_pwm_axil_slave: RTL and testbench

RGB_PWM_AXIL_SLAVE -- requirements
Module: rgb_pwm_axil_slave

---
 rtl/ledsrgb_pkg.sv | 39 +++
 rtl/rgb_pwm_core.sv | 60 ++++++
 rtl/rgb_pwm_axil_slave.sv | 147 ++++++++++++++
 tb/tb_rgb_pwm_axil_slave.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledsrgb_pkg.sv
// ---------------------------------------------------------------------------
// ledsrgb_pkg
// Shared definitions for the RGB PWM AXI4-Lite peripheral: register word
// indices, CTRL field positions, the AXI OKAY response code, the default PWM
// width and a byte-strobe merge helper.
// ---------------------------------------------------------------------------
package ledsrgb_pkg;

  localparam int PWM_BITS_DEFAULT = 8;
  localparam int NUM_REGS         = 4;

  // Register word index taken from addr[3:2].
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_DUTY_R = 2'd1,
    REG_DUTY_G = 2'd2,
    REG_DUTY_B = 2'd3
  } reg_idx_e;

  // CTRL fields. All other CTRL bits are plain storage.
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int CTRL_PRESCALE_W   = 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] strobe_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rgb_pwm_core.sv
// ---------------------------------------------------------------------------
// rgb_pwm_core
// Prescaler, free-running PWM counter and three duty comparators.
//   clk, rst_n         : clock, asynchronous active-low reset
//   enable             : 0 holds prescaler/counter at zero and LEDs low
//   prescale           : counter advances once every prescale+1 cycles
//   duty_r/g/b         : LED is high while counter < duty
//   led_r/g/b          : registered PWM outputs, active-high
// ---------------------------------------------------------------------------
module rgb_pwm_core #(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PWM_BITS-1:0]   duty_r,
  input  logic [PWM_BITS-1:0]   duty_g,
  input  logic [PWM_BITS-1:0]   duty_b,
  output logic                  led_r,
  output logic                  led_g,
  output logic                  led_b
);

  logic [PRESCALE_W-1:0] presc_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make ordering between blocks matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      led_r     <= 1'b0;
      led_g     <= 1'b0;
      led_b     <= 1'b0;
    end else if (!enable) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      led_r     <= 1'b0;
      led_g     <= 1'b0;
      led_b     <= 1'b0;
    end else begin
      // Compare against the current count; duties apply on the next compare.
      led_r <= (pwm_cnt < duty_r);
      led_g <= (pwm_cnt < duty_g);
      led_b <= (pwm_cnt < duty_b);
      // '>=' rather than '==' so lowering the prescale mid-count cannot
      // strand the prescaler above its terminal value.
      if (presc_cnt >= prescale) begin
        presc_cnt <= '0;
        pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      end else begin
        presc_cnt <= presc_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_pwm_axil_slave.sv
// ---------------------------------------------------------------------------
// rgb_pwm_axil_slave
// AXI4-Lite slave with four 32-bit registers driving an RGB PWM core.
//   S_AXI_ACLK, S_AXI_ARESETN   : clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*             : write address/data/response channels
//   S_AXI_AR*/R*                : read address/data channels
//   led_r, led_g, led_b         : registered PWM outputs
// Map (addr[3:2]): 0 CTRL (bit0 enable, [15:8] prescale), 1..3 DUTY_R/G/B.
// AW and W are latched independently; the register is written on the cycle
// both are held, and BVALID follows one cycle later.
// ---------------------------------------------------------------------------
module rgb_pwm_axil_slave
  import ledsrgb_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_BITS           = PWM_BITS_DEFAULT
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            led_r,
  output logic                            led_g,
  output logic                            led_b
);

  // Goes high on the first edge after reset release so READYs stay low
  // throughout reset and rise one cycle after it.
  logic                            axi_live;
  logic                            aw_latched;
  logic                            w_latched;
  logic [1:0]                      aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic                            bvalid_q;
  logic                            rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic wr_commit;

  assign S_AXI_AWREADY = axi_live && !aw_latched && !bvalid_q;
  assign S_AXI_WREADY  = axi_live && !w_latched  && !bvalid_q;
  assign S_AXI_ARREADY = axi_live && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign wr_commit = aw_latched && w_latched;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      axi_live   <= 1'b0;
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      aw_idx     <= 2'd0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      // NOTE: the register file is only four words of flops, so it is cleared
      // on reset; a true RAM would be left uninitialised instead.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      axi_live <= 1'b1;

      if (aw_hs) begin
        aw_latched <= 1'b1;
        aw_idx     <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_latched <= 1'b1;
        wdata_q   <= S_AXI_WDATA;
        wstrb_q   <= S_AXI_WSTRB;
      end

      // A handshake needs an empty latch, a commit needs both full, so the
      // two can never coincide on the same channel.
      if (wr_commit) begin
        regs[aw_idx] <= strobe_merge(regs[aw_idx], wdata_q, wstrb_q);
        aw_latched   <= 1'b0;
        w_latched    <= 1'b0;
        bvalid_q     <= 1'b1;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      // regs[] still holds its pre-edge value here, so a read landing on the
      // same edge as a write to that word returns the old contents.
      if (ar_hs) begin
        rdata_q  <= regs[S_AXI_ARADDR[3:2]];
        rvalid_q <= 1'b1;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Protection attributes and sub-word address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  rgb_pwm_core #(
    .PWM_BITS   (PWM_BITS),
    .PRESCALE_W (CTRL_PRESCALE_W)
  ) u_core (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .enable   (regs[REG_CTRL][CTRL_ENABLE_BIT]),
    .prescale (regs[REG_CTRL][CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W]),
    .duty_r   (regs[REG_DUTY_R][PWM_BITS-1:0]),
    .duty_g   (regs[REG_DUTY_G][PWM_BITS-1:0]),
    .duty_b   (regs[REG_DUTY_B][PWM_BITS-1:0]),
    .led_r    (led_r),
    .led_g    (led_g),
    .led_b    (led_b)
  );

endmodule

// File: tb/tb_rgb_pwm_axil_slave.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_axil_slave
// Self-checking bench: directed AXI corner cases plus randomized register
// traffic against a word/byte register model, and PWM duty measured as the
// number of high cycles over one full period (duty * (P+1)).
// ---------------------------------------------------------------------------
module tb_rgb_pwm_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        led_r, led_g, led_b;

  always #5 clk = ~clk;

  rgb_pwm_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .led_r         (led_r),
    .led_g         (led_g),
    .led_b         (led_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference register file, indexed by word.
  logic [31:0] model [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  // Full write. hold>0 keeps BREADY low that many cycles after BVALID and
  // checks the response is held; abandon returns with BVALID still pending.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold, input bit abandon,
                           output logic [1:0] resp);
    bit aw_done, w_done, a, w;
    int n;
    aw_done = 0; w_done = 0; n = 0; resp = 2'bxx;
    @(negedge clk);
    awaddr = addr; awprot = 3'($urandom); awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 32) begin
      a = awvalid && awready;
      w = wvalid && wready;
      @(negedge clk); n++;
      if (a) begin awvalid = 1'b0; aw_done = 1; end
      if (w) begin wvalid = 1'b0; w_done = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin check("write_hs_timeout", 0, 1); return; end
    n = 0;
    while (!bvalid && n < 32) begin @(negedge clk); n++; end
    if (!bvalid) begin check("bvalid_timeout", 0, 1); return; end
    resp = bresp;
    if (abandon) return;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("b_hold_bvalid", bvalid, 1);
      check("b_hold_bresp", bresp, 2'b00);
      check("b_hold_awready", awready, 0);
      check("b_hold_wready", wready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0; data = 'x; resp = 2'bxx;
    @(negedge clk);
    araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
    while (!arready && n < 32) begin @(negedge clk); n++; end
    if (!arready) begin check("ar_timeout", 0, 1); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 32) begin @(negedge clk); n++; end
    if (!rvalid) begin check("rvalid_timeout", 0, 1); return; end
    data = rdata; resp = rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("r_hold_rvalid", rvalid, 1);
      check("r_hold_rdata", rdata, data);
      check("r_hold_arready", arready, 0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic reg_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] resp;
    axi_write(addr, data, strb, 0, 0, resp);
    check("write_bresp", resp, 2'b00);
    model[addr[3:2]] = byte_merge(model[addr[3:2]], data, strb);
  endtask

  task automatic reg_read_check(input logic [3:0] addr, input string tag);
    logic [31:0] d;
    logic [1:0]  resp;
    axi_read(addr, 0, d, resp);
    check(tag, d, model[addr[3:2]]);
    check("read_rresp", resp, 2'b00);
  endtask

  // Over any full PWM period each LED is high for exactly duty*(P+1) cycles.
  task automatic pwm_window(input int p, input string tag);
    int cr, cg, cb;
    cr = 0; cg = 0; cb = 0;
    repeat (4) @(negedge clk);
    repeat (256 * (p + 1)) begin
      @(negedge clk);
      cr += int'(led_r); cg += int'(led_g); cb += int'(led_b);
    end
    check({tag, "_r"}, cr, int'(model[1][7:0]) * (p + 1));
    check({tag, "_g"}, cg, int'(model[2][7:0]) * (p + 1));
    check({tag, "_b"}, cb, int'(model[3][7:0]) * (p + 1));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int          n, p, cnt;
    logic [31:0] d, old;
    logic [1:0]  resp;
    logic [3:0]  a, s;

    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state while clock runs.
    #100;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_resp", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, 0);
    check("rst_leds", {led_r, led_g, led_b}, 3'b000);
    #100;
    rst_n = 1'b1;               // released at a falling edge
    #1;
    check("release_awready_low", awready, 0);
    @(negedge clk);
    check("release_awready_high", awready, 1);
    check("release_arready_high", arready, 1);

    // Basic write then read-back.
    for (int i = 0; i < 4; i++) reg_write(4'(4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) reg_read_check(4'(4 * i), "basic_readback");

    // Partial strobe over zero.
    reg_write(4'h8, 32'h0, 4'hF);
    reg_write(4'h8, 32'hAABBCCDD, 4'b0101);
    reg_read_check(4'h8, "wstrb_0101");
    check("wstrb_model", model[2], 32'h00BB00DD);

    // Randomized traffic; sub-word address bits and strobes are random.
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      reg_write(a, d, s);
      reg_read_check(4'($urandom_range(0, 15)), "rand_readback");
    end

    // AW three cycles ahead of W.
    @(negedge clk);
    awaddr = 4'h4; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("awfirst_awready", awready, 1);
    @(negedge clk); awvalid = 1'b0;
    repeat (3) begin
      check("awfirst_wait_bvalid", bvalid, 0);
      check("awfirst_wait_awready", awready, 0);
      @(negedge clk);
    end
    d = $urandom; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    check("awfirst_wready", wready, 1);
    @(negedge clk); wvalid = 1'b0;
    check("awfirst_bvalid_early", bvalid, 0);
    @(negedge clk);
    check("awfirst_bvalid", bvalid, 1);
    check("awfirst_bresp", bresp, 2'b00);
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    check("awfirst_single_resp", bvalid, 0);
    model[1] = d;

    // W three cycles ahead of AW.
    d = $urandom; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    check("wfirst_wready", wready, 1);
    @(negedge clk); wvalid = 1'b0;
    repeat (3) begin
      check("wfirst_wait_bvalid", bvalid, 0);
      check("wfirst_wait_wready", wready, 0);
      @(negedge clk);
    end
    awaddr = 4'hC; awvalid = 1'b1;
    check("wfirst_awready", awready, 1);
    @(negedge clk); awvalid = 1'b0;
    check("wfirst_bvalid_early", bvalid, 0);
    @(negedge clk);
    check("wfirst_bvalid", bvalid, 1);
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    check("wfirst_single_resp", bvalid, 0);
    model[3] = d;
    reg_read_check(4'h4, "awfirst_readback");
    reg_read_check(4'hC, "wfirst_readback");

    // Back-pressure on both response channels.
    d = $urandom;
    axi_write(4'h0, d, 4'hF, 5, 0, resp);
    check("bp_bresp", resp, 2'b00);
    model[0] = d;
    axi_read(4'h0, 5, old, resp);
    check("bp_rdata", old, model[0]);
    check("bp_rresp", resp, 2'b00);

    // Read and write of the same word resolving on the same edge.
    old = model[2]; d = ~old;
    @(negedge clk);
    check("collide_awready", awready, 1);
    awaddr = 4'h8; awvalid = 1'b1; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'h8; arvalid = 1'b1;
    check("collide_arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    check("collide_rvalid", rvalid, 1);
    check("collide_rdata_old", rdata, old);
    check("collide_bvalid", bvalid, 1);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    model[2] = d;
    reg_read_check(4'h8, "collide_readback_new");

    // PWM duty over a period: fixed boundary duties, then prescale 3.
    reg_write(4'h4, 32'd64, 4'hF);
    reg_write(4'h8, 32'd0, 4'hF);
    reg_write(4'hC, 32'd255, 4'hF);
    reg_write(4'h0, 32'h1, 4'hF);
    pwm_window(0, "pwm_p0");
    reg_write(4'h0, 32'h0301, 4'hF);
    pwm_window(3, "pwm_p3");

    // Random duties and prescale; upper bits are storage only.
    for (int i = 0; i < 3; i++) begin
      p = $urandom_range(0, 3);
      reg_write(4'h4, $urandom, 4'hF);
      reg_write(4'h8, $urandom, 4'hF);
      reg_write(4'hC, $urandom, 4'hF);
      reg_write(4'h0, ($urandom & 32'hFFFF_00FE) | 32'(p << 8) | 32'h1, 4'hF);
      pwm_window(p, "pwm_rand");
    end

    // Disabled: LEDs stay low.
    reg_write(4'h0, 32'h0300, 4'hF);
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (300) begin @(negedge clk); cnt += int'(led_r | led_g | led_b); end
    check("disabled_leds_high_cycles", cnt, 0);

    // Re-enable with P=1: counter restarts from 0. reg_write returns at the
    // falling edge after the cycle following the enabling write, so the m-th
    // sample reflects count floor((m-1)/(P+1)).
    reg_write(4'h4, 32'd2, 4'hF);
    reg_write(4'h8, 32'd5, 4'hF);
    reg_write(4'hC, 32'd0, 4'hF);
    reg_write(4'h0, 32'h0101, 4'hF);
    for (int m = 1; m <= 24; m++) begin
      check("reenable_led_r", led_r, 1'(((m - 1) / 2) % 256 < 2));
      check("reenable_led_g", led_g, 1'(((m - 1) / 2) % 256 < 5));
      check("reenable_led_b", led_b, 1'b0);
      @(negedge clk);
    end

    // Reset with a write response pending.
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 1, resp);
    check("pending_bvalid", bvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bvalid", bvalid, 0);
    check("async_rst_awready", awready, 0);
    check("async_rst_leds", {led_r, led_g, led_b}, 3'b000);
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bready = 1'b1;
    repeat (3) begin @(negedge clk); check("post_rst_no_bvalid", bvalid, 0); end
    bready = 1'b0;
    for (int i = 0; i < 4; i++) reg_read_check(4'(4 * i), "post_rst_readback");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
